// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the multi-channel reset sequencer.
// Imported by the sequencer top and anything that needs its state encoding.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  // Counter must reach the larger of the hold and step intervals.
  function automatic int cnt_width(input int hold_cycles, input int step_cycles);
    int longest;
    longest = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
    return $clog2(longest + 1);
  endfunction

  // Slot index runs 0..nch, the final value meaning every slot has completed.
  function automatic int slot_width(input int nch);
    return $clog2(nch + 1);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-deassert reset synchroniser; o_rst_s is the last stage.
// Even a sub-cycle pulse on i_rst sets every stage, forcing a full release delay.
module reset_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst_s
);

  logic [SYNC_STAGES-1:0] r_chain;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign o_rst_s = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NCH per-domain resets one at a time after a synchronised hold period,
// with software re-sequencing, a per-channel enable mask and done/busy status.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 4
) (
  input  logic           CLK,
  input  logic           IN_RST,
  input  logic           SW_RST,
  input  logic [NCH-1:0] CH_EN,
  output logic [NCH-1:0] OUT_RST,
  output logic           RST_DONE,
  output logic           BUSY
);

  localparam int CW = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int SW = slot_width(NCH);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_END  = SW'(NCH);

  state_t         r_state, w_state_next;
  logic [CW-1:0]  r_cnt,   w_cnt_next;
  logic [SW-1:0]  r_slot,  w_slot_next;
  logic [NCH-1:0] r_out,   w_out_next;
  logic           r_done,  w_done_next;
  logic           w_rst_s;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (CLK),
    .i_rst  (IN_RST),
    .o_rst_s(w_rst_s)
  );

  always_ff @(posedge CLK or posedge IN_RST) begin
    if (IN_RST) begin
      r_state <= ST_SYNC;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_out   <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_slot  <= w_slot_next;
      r_out   <= w_out_next;
      r_done  <= w_done_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_slot_next  = r_slot;
    w_out_next   = r_out;

    case (r_state)
      ST_SYNC: begin
        if (!w_rst_s) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
        end
      end

      ST_HOLD: begin
        w_out_next = '1;
        if (r_cnt == HOLD_LAST) begin
          w_state_next = ST_RELEASE;
          w_cnt_next   = '0;
          w_slot_next  = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_RELEASE: begin
        // Channels already released fall back into reset if their enable drops.
        w_out_next = r_out | ~CH_EN;
        if (r_slot == SLOT_END) begin
          w_state_next = ST_RUN;
        end else if (r_cnt == STEP_LAST) begin
          w_cnt_next  = '0;
          w_slot_next = r_slot + 1'b1;
          for (int k = 0; k < NCH; k++) begin
            if (r_slot == SW'(k)) w_out_next[k] = ~CH_EN[k];
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        w_out_next = r_out | ~CH_EN;
      end
    endcase

    // Software re-reset beats any slot completion on the same edge.
    if (SW_RST && (r_state != ST_SYNC)) begin
      w_state_next = ST_HOLD;
      w_cnt_next   = '0;
      w_out_next   = '1;
    end

    w_done_next = (w_state_next == ST_RUN);
  end

  assign OUT_RST  = r_out;
  assign RST_DONE = r_done;
  assign BUSY     = ~r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus predicts output-change events
// from the timing rules; a negedge monitor pops and compares each observed change.
module tb_reset_sequencer;

  localparam int NCH         = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int STEP_CYCLES = 4;
  localparam int RUN_FROM_HOLD = HOLD_CYCLES + STEP_CYCLES * NCH + 1;
  localparam logic [NCH-1:0] ALL = '1;

  logic           CLK = 1'b0;
  logic           IN_RST;
  logic           SW_RST;
  logic [NCH-1:0] CH_EN;
  logic [NCH-1:0] OUT_RST;
  logic           RST_DONE;
  logic           BUSY;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    int             at_edge;
    logic [NCH-1:0] out;
    logic           done;
  } ev_t;

  ev_t            exp_q[$];
  logic [NCH-1:0] m_out  = ALL;
  logic           m_done = 1'b0;
  int             cur_h  = 0;
  logic [NCH-1:0] cur_en = ALL;

  reset_sequencer #(
    .NCH        (NCH),
    .SYNC_STAGES(SYNC_STAGES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .STEP_CYCLES(STEP_CYCLES)
  ) dut (
    .CLK     (CLK),
    .IN_RST  (IN_RST),
    .SW_RST  (SW_RST),
    .CH_EN   (CH_EN),
    .OUT_RST (OUT_RST),
    .RST_DONE(RST_DONE),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Outputs of a sequence whose HOLD began at edge h, observed after edge e.
  function automatic logic [NCH-1:0] seq_out(input int h, input logic [NCH-1:0] en, input int e);
    logic [NCH-1:0] v;
    v = ALL;
    for (int k = 0; k < NCH; k++)
      if (en[k] && e >= h + HOLD_CYCLES + STEP_CYCLES * (k + 1)) v[k] = 1'b0;
    return v;
  endfunction

  task automatic push_ev(input int e, input logic [NCH-1:0] o, input logic d);
    ev_t ev;
    ev.at_edge = e;
    ev.out     = o;
    ev.done    = d;
    exp_q.push_back(ev);
    m_out  = o;
    m_done = d;
  endtask

  task automatic predict_seq(input int h, input logic [NCH-1:0] en);
    logic [NCH-1:0] v;
    logic           d;
    cur_h  = h;
    cur_en = en;
    for (int e = h; e <= h + RUN_FROM_HOLD; e++) begin
      v = seq_out(h, en, e);
      d = (e >= h + RUN_FROM_HOLD);
      if (v !== m_out || d !== m_done) push_ev(e, v, d);
    end
  endtask

  // Drop predictions beyond now when a sequence is interrupted.
  task automatic cancel_future();
    while (exp_q.size() > 0 && exp_q[$].at_edge > edge_cnt) void'(exp_q.pop_back());
    m_out  = seq_out(cur_h, cur_en, edge_cnt);
    m_done = (edge_cnt >= cur_h + RUN_FROM_HOLD);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // hold_ticks == 0 gives a 1 ns glitch between edges.
  task automatic hard_reset(input int hold_ticks);
    if (m_out !== ALL || m_done !== 1'b0) push_ev(edge_cnt, ALL, 1'b0);
    IN_RST = 1'b1;
    #1;
    check("async_assert", 32'({OUT_RST, RST_DONE, BUSY}), 32'({ALL, 1'b0, 1'b1}));
    if (hold_ticks == 0) begin
      IN_RST = 1'b0;
    end else begin
      repeat (hold_ticks) tick();
      IN_RST = 1'b0;
    end
    predict_seq(edge_cnt + SYNC_STAGES + 1, CH_EN);
  endtask

  task automatic sw_reseq();
    SW_RST = 1'b1;
    tick();
    SW_RST = 1'b0;
    predict_seq(edge_cnt, CH_EN);
  endtask

  task automatic set_en(input logic [NCH-1:0] en_new);
    logic [NCH-1:0] nv;
    CH_EN = en_new;
    nv = m_out | ~en_new;
    if (nv !== m_out) push_ev(edge_cnt + 1, nv, m_done);
  endtask

  task automatic drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  logic [NCH+1:0] prev = {ALL, 1'b0, 1'b1};

  always @(negedge CLK) begin : monitor
    logic [NCH+1:0] cur;
    ev_t            ev;
    cur = {OUT_RST, RST_DONE, BUSY};
    if (cur !== prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change actual=%0h previous=%0h (edge %0d)", cur, prev, edge_cnt);
      end else begin
        ev = exp_q.pop_front();
        check("event_edge", 32'(edge_cnt), 32'(ev.at_edge));
        check("event_value", 32'(cur), 32'({ev.out, ev.done, ~ev.done}));
      end
      prev = cur;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] en_r;
    IN_RST = 1'b1;
    SW_RST = 1'b0;
    CH_EN  = ALL;
    #1;
    check("reset_values", 32'({OUT_RST, RST_DONE, BUSY}), 32'({ALL, 1'b0, 1'b1}));

    // Power-on release with all channels enabled.
    repeat (3) tick();
    IN_RST = 1'b0;
    predict_seq(edge_cnt + SYNC_STAGES + 1, CH_EN);
    repeat (38) tick();
    drained("t1_power_on");

    // Partial enable mask, full restart from IN_RST.
    set_en(4'b0101);
    repeat (2) tick();
    hard_reset(2);
    repeat (38) tick();
    drained("t2_mask_0101");

    // Single-cycle SW_RST in RUN.
    set_en(ALL);
    repeat (3) tick();
    sw_reseq();
    repeat (35) tick();
    drained("t3_sw_rst");

    // IN_RST mid-RELEASE (between edges 25 and 26), SW_RST held during SYNC.
    hard_reset(2);
    for (int i = 0; i < 40 && edge_cnt < cur_h - SYNC_STAGES - 1 + 25; i++) tick();
    check("t4_at_edge25", 32'(edge_cnt), 32'(cur_h - SYNC_STAGES - 1 + 25));
    cancel_future();
    hard_reset(3);
    SW_RST = 1'b1;
    tick();
    tick();
    SW_RST = 1'b0;
    repeat (36) tick();
    drained("t4_mid_release");

    // 1 ns IN_RST glitch while in RUN.
    repeat (2) tick();
    hard_reset(0);
    repeat (38) tick();
    drained("t5_glitch");

    // Enable drop and re-raise in RUN.
    set_en(4'b1011);
    repeat (3) tick();
    check("t6_done_held", 32'(RST_DONE), 32'd1);
    set_en(ALL);
    repeat (5) tick();
    check("t6_ch2_held", 32'(OUT_RST[2]), 32'd1);
    drained("t6_en_change");
    sw_reseq();
    repeat (35) tick();
    drained("t6_reseq");

    // Randomised masks and restart sources.
    for (int it = 0; it < 6; it++) begin
      en_r = NCH'($urandom_range(0, (1 << NCH) - 1));
      set_en(en_r);
      repeat (2 + $urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) == 1) sw_reseq();
      else hard_reset(int'($urandom_range(0, 3)));
      repeat (40) tick();
      drained("rand_seq");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output reset synchroniser.
- Takes one asynchronous active-high reset and produces NCH per-domain resets.
  - Assertion is asynchronous; deassertion is synchronised.
  - After a hold period, channels are released one at a time in index order, spaced by a fixed step.
- Adds a synchronous software re-reset request, per-channel enable mask and a done/busy status.
- Sits at the top of each clock domain, ahead of the Bluespec-generated logic.

Parameters:
- NCH, 4: number of reset output channels (>=1).
- SYNC_STAGES, 2: deassertion synchroniser depth (>=2).
- HOLD_CYCLES, 16: cycles all outputs stay asserted after synchronised release or SW_RST (>=1).
- STEP_CYCLES, 4: cycles between successive channel release slots (>=1).

Ports:
- CLK  in  1  domain clock.
- IN_RST  in  1  reset; asynchronous, active-high; asserts everything immediately.
- SW_RST  in  1  synchronous request, sampled high on a CLK edge; restarts the sequence.
- CH_EN  in  NCH  channel enable mask; a 0 bit holds that channel in reset.
- OUT_RST  out  NCH  active-high per-channel resets, driven directly from flops.
- RST_DONE  out  1  high once the sequence has completed (state RUN).
- BUSY  out  1  high whenever state != RUN.

Behaviour:
- Reset values, applied asynchronously while IN_RST=1:
  - OUT_RST all 1, RST_DONE 0, BUSY 1.
  - Synchroniser chain all 1, state SYNC, counters 0.
- Synchroniser: SYNC_STAGES flops with async set from IN_RST, D input 0; the last stage is rst_s.
  - Any IN_RST pulse, including one shorter than a cycle, forces a full sequence.
- Timing: edge 1 is the first CLK rising edge after IN_RST falls. rst_s goes low after edge SYNC_STAGES.
- FSM states and transitions:
  - SYNC: wait for rst_s=0. Goes to HOLD at edge SYNC_STAGES+1 with cnt=0.
  - HOLD: all OUT_RST=1. Counts HOLD_CYCLES cycles, then goes to RELEASE with slot=0, cnt=0.
  - RELEASE:
    - Every STEP_CYCLES cycles, slot k completes: OUT_RST[k] <= ~CH_EN[k], then slot increments.
    - Disabled channels still consume their slot, so timing is deterministic.
    - After slot NCH-1 completes, go to RUN next edge. RST_DONE rises on that edge.
  - RUN: RST_DONE=1, BUSY=0. Outputs hold.
- SW_RST:
  - Sampled in HOLD, RELEASE or RUN: on that edge all OUT_RST go to 1, RST_DONE to 0, and the FSM goes to HOLD with cnt=0.
  - Sampled in SYNC: ignored.
- CH_EN:
  - In RUN, a bit going 1->0 asserts OUT_RST[k] on the next edge; RST_DONE stays 1.
  - A bit going 0->1 in RUN does not release the channel; the channel is only released by a later sequence.
  - A released channel (k < slot) in RELEASE is treated the same way as in RUN.
- Simultaneous events:
  - IN_RST overrides everything.
  - SW_RST on the same edge as a slot completion wins; no channel is released on that edge.
- Counter width: clog2(max(HOLD_CYCLES,STEP_CYCLES)+1). Slot index width: clog2(NCH+1).
- Glitch rules: outputs are registered only; no combinational path from CH_EN or SW_RST to OUT_RST.
- Expected timing with defaults (SYNC_STAGES=2, HOLD_CYCLES=16, STEP_CYCLES=4):
  - HOLD entered at edge 3; RELEASE entered at edge 19.
  - OUT_RST[0..3] fall at edges 23, 27, 31, 35.
  - RST_DONE rises at edge 36.

Decomposition:
- Package rst_seq_pkg holds:
  - state encoding enum (SYNC, HOLD, RELEASE, RUN);
  - a function computing counter width from the parameters.
- One sub-module, reset_sync_chain: async-assert/sync-deassert chain parametrised by SYNC_STAGES, output rst_s.

Test Plan:
1. Power-on with defaults, CH_EN=4'hF, IN_RST pulsed then released -> OUT_RST bits fall at edges 23/27/31/35; RST_DONE 0->1 at edge 36; BUSY falls at edge 36.
2. CH_EN=4'b0101 -> OUT_RST[0] falls at edge 23 and OUT_RST[2] at edge 31; bits 1 and 3 stay 1; RST_DONE rises at edge 36.
3. SW_RST high for one cycle at edge N in RUN -> OUT_RST=4'hF and RST_DONE=0 after edge N; RELEASE at N+16; OUT_RST[0] falls at N+20; RST_DONE rises at N+33.
4. IN_RST asserted between edges 25 and 26 (mid-RELEASE) -> OUT_RST=4'hF with no clock edge; full default timing restarts from the IN_RST falling edge.
5. IN_RST glitch of 1 ns placed mid-cycle while in RUN -> full sequence re-run; RST_DONE low for 36 edges.
6. In RUN, CH_EN[2] cleared -> OUT_RST[2]=1 on the next edge with RST_DONE still 1. CH_EN[2] set again -> OUT_RST[2] stays 1 until SW_RST re-sequences it.
